// File: rtl/heap_arbiter.sv
// rtl/heap_arbiter.sv - two-client request/grant arbiter and result router in front of the alloc block
// Optional feature: HEAP_ARB_COMBINE_EN pairs an alloc with a simultaneous free into one cycle.
module heap_arbiter #(
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_a_req,
  input  logic [1:0]         i_a_op,
  input  logic [DATA_SZ-1:0] i_a_addr,
  input  logic [DATA_SZ-1:0] i_a_data,
  input  logic               i_b_req,
  input  logic [1:0]         i_b_op,
  input  logic [DATA_SZ-1:0] i_b_addr,
  input  logic [DATA_SZ-1:0] i_b_data,
  output logic               o_a_gnt,
  output logic               o_b_gnt,
  output logic               o_a_done,
  output logic               o_b_done,
  output logic [DATA_SZ-1:0] o_a_rdata,
  output logic [DATA_SZ-1:0] o_b_rdata,
  output logic               o_al,
  output logic               o_fr,
  output logic               o_wr,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_adata,
  output logic [DATA_SZ-1:0] o_faddr,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_aaddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_err,
  output logic               o_err
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  localparam logic [1:0] OP_AL = 2'b00;
  localparam logic [1:0] OP_FR = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_ALLOC = 2'd1;
  localparam logic [1:0] K_READ  = 2'd2;
  localparam logic [1:0] K_OTHER = 2'd3;

  logic [0:0] state_q;
  logic       ptr_q;
  logic [1:0] a_kind_q;
  logic [1:0] b_kind_q;
  logic       blocked;
  logic       combine;

  function automatic logic [1:0] kind_of(input logic [1:0] op);
    case (op)
      OP_AL:   kind_of = K_ALLOC;
      OP_RD:   kind_of = K_READ;
      default: kind_of = K_OTHER;
    endcase
  endfunction

  assign blocked = (state_q == S_HALT) || i_err || !i_rst_n;

`ifdef HEAP_ARB_COMBINE_EN
  assign combine = i_a_req && i_b_req &&
                   ((i_a_op == OP_AL && i_b_op == OP_FR) || (i_a_op == OP_FR && i_b_op == OP_AL));
`else
  assign combine = 1'b0;
`endif

  // ptr_q == 0 favours A when both request
  assign o_a_gnt = !blocked && i_a_req && (!i_b_req || !ptr_q || combine);
  assign o_b_gnt = !blocked && i_b_req && (!i_a_req ||  ptr_q || combine);

  always_comb begin
    o_al = 1'b0; o_fr = 1'b0; o_wr = 1'b0; o_rd = 1'b0;
    o_adata = '0; o_faddr = '0; o_waddr = '0; o_wdata = '0; o_raddr = '0;
    if (o_b_gnt) begin
      case (i_b_op)
        OP_AL:   begin o_al = 1'b1; o_adata = i_b_data; end
        OP_FR:   begin o_fr = 1'b1; o_faddr = i_b_addr; end
        OP_WR:   begin o_wr = 1'b1; o_waddr = i_b_addr; o_wdata = i_b_data; end
        default: begin o_rd = 1'b1; o_raddr = i_b_addr; end
      endcase
    end
    if (o_a_gnt) begin
      case (i_a_op)
        OP_AL:   begin o_al = 1'b1; o_adata = i_a_data; end
        OP_FR:   begin o_fr = 1'b1; o_faddr = i_a_addr; end
        OP_WR:   begin o_wr = 1'b1; o_waddr = i_a_addr; o_wdata = i_a_data; end
        default: begin o_rd = 1'b1; o_raddr = i_a_addr; end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_RUN;
      ptr_q    <= 1'b0;
      a_kind_q <= K_NONE;
      b_kind_q <= K_NONE;
    end else begin
      if (i_err) state_q <= S_HALT;
      a_kind_q <= o_a_gnt ? kind_of(i_a_op) : K_NONE;
      b_kind_q <= o_b_gnt ? kind_of(i_b_op) : K_NONE;
      if (o_a_gnt && i_b_req && !combine)      ptr_q <= 1'b1;
      else if (o_b_gnt && i_a_req && !combine) ptr_q <= 1'b0;
    end
  end

  assign o_a_done = (a_kind_q != K_NONE);
  assign o_b_done = (b_kind_q != K_NONE);
  assign o_err    = (state_q == S_HALT) || i_err;

  // An error in the result cycle poisons the returned data.
  always_comb begin
    o_a_rdata = '0;
    o_b_rdata = '0;
    if (!i_err) begin
      if (a_kind_q == K_ALLOC)     o_a_rdata = i_aaddr;
      else if (a_kind_q == K_READ) o_a_rdata = i_rdata;
      if (b_kind_q == K_ALLOC)     o_b_rdata = i_aaddr;
      else if (b_kind_q == K_READ) o_b_rdata = i_rdata;
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// tb/tb_heap_arbiter.sv - directed and randomized bench for heap_arbiter with a mock allocator
module tb_heap_arbiter;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, b_req, err_in;
  logic [1:0]  a_op, b_op;
  logic [15:0] a_addr, b_addr, a_data, b_data;
  logic        a_gnt, b_gnt, a_done, b_done, al, fr, wr, rd, err_out;
  logic [15:0] a_rdata, b_rdata, adata, faddr, waddr, wdata, raddr, aaddr, rdata;

  heap_arbiter #(.DATA_SZ(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_op(a_op), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_req(b_req), .i_b_op(b_op), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_a_gnt(a_gnt), .o_b_gnt(b_gnt), .o_a_done(a_done), .o_b_done(b_done),
    .o_a_rdata(a_rdata), .o_b_rdata(b_rdata),
    .o_al(al), .o_fr(fr), .o_wr(wr), .o_rd(rd),
    .o_adata(adata), .o_faddr(faddr), .o_waddr(waddr), .o_wdata(wdata), .o_raddr(raddr),
    .i_aaddr(aaddr), .i_rdata(rdata), .i_err(err_in), .o_err(err_out)
  );

  // Mock allocator: bump-pointer allocation from 0x5000, small word memory, free passed through on combine
  logic [15:0] mock_cnt;
  logic [15:0] mock_mem [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mock_cnt <= 16'h5000;
      aaddr    <= 16'h0000;
      rdata    <= 16'h0000;
      for (int i = 0; i < 16; i++) mock_mem[i] <= 16'h0000;
    end else begin
      if (wr) mock_mem[waddr[3:0]] <= wdata;
      if (rd) rdata <= mock_mem[raddr[3:0]];
      if (al && fr) aaddr <= faddr;
      else if (al) begin
        aaddr    <= mock_cnt;
        mock_cnt <= mock_cnt + 16'd1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  req_t        qa[$], qb[$];
  bit          cur_v [2];
  req_t        cur [2];
  int          r_ptr;
  bit          r_halt;
  logic [15:0] r_cnt;
  logic [15:0] r_mem [16];
  bit          exp_done [2];
  logic [15:0] exp_rd [2];
  logic        obs_a_gnt, obs_b_gnt, obs_a_done, obs_b_done, obs_err;
  logic [15:0] obs_a_rdata, obs_b_rdata, obs_adata;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    req_t r;
    r.op = op; r.addr = addr; r.data = data;
    if (c == 0) qa.push_back(r); else qb.push_back(r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    r_ptr = 0; r_halt = 1'b0; r_cnt = 16'h5000;
    exp_done[0] = 1'b0; exp_done[1] = 1'b0;
    for (int i = 0; i < 16; i++) r_mem[i] = 16'h0000;
    chk("rst_a_gnt", a_gnt, 0);    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_done", a_done, 0);  chk("rst_b_done", b_done, 0);
    chk("rst_strobes", {al, fr, wr, rd}, 0);
    chk("rst_a_rdata", a_rdata, 0); chk("rst_b_rdata", b_rdata, 0);
    chk("rst_adata", adata, 0);    chk("rst_err", err_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus, comparison against the reference model, and model update
  task automatic cycle();
    bit halted, comb;
    bit g [2];
    bit e_al, e_fr, e_wr, e_rd;
    logic [15:0] e_adata, e_faddr, e_waddr, e_wdata, e_raddr;
    logic [15:0] nxt_rd [2];
    if (!cur_v[0] && qa.size() > 0) begin cur[0] = qa.pop_front(); cur_v[0] = 1'b1; end
    if (!cur_v[1] && qb.size() > 0) begin cur[1] = qb.pop_front(); cur_v[1] = 1'b1; end
    a_req = cur_v[0]; a_op = cur[0].op; a_addr = cur[0].addr; a_data = cur[0].data;
    b_req = cur_v[1]; b_op = cur[1].op; b_addr = cur[1].addr; b_data = cur[1].data;
    @(negedge clk);
    halted = r_halt || err_in;
    comb = 1'b0;
`ifdef HEAP_ARB_COMBINE_EN
    comb = cur_v[0] && cur_v[1] && ((cur[0].op == 2'd0 && cur[1].op == 2'd1) ||
                                    (cur[0].op == 2'd1 && cur[1].op == 2'd0));
`endif
    g[0] = !halted && cur_v[0] && (!cur_v[1] || r_ptr == 0 || comb);
    g[1] = !halted && cur_v[1] && (!cur_v[0] || r_ptr == 1 || comb);
    e_al = 0; e_fr = 0; e_wr = 0; e_rd = 0;
    e_adata = 0; e_faddr = 0; e_waddr = 0; e_wdata = 0; e_raddr = 0;
    for (int c = 0; c < 2; c++) if (g[c]) begin
      case (cur[c].op)
        2'd0: begin e_al = 1; e_adata = cur[c].data; end
        2'd1: begin e_fr = 1; e_faddr = cur[c].addr; end
        2'd2: begin e_wr = 1; e_waddr = cur[c].addr; e_wdata = cur[c].data; end
        default: begin e_rd = 1; e_raddr = cur[c].addr; end
      endcase
    end
    chk("a_gnt", a_gnt, g[0]);  chk("b_gnt", b_gnt, g[1]);
    chk("err", err_out, halted);
    chk("strobes", {al, fr, wr, rd}, {e_al, e_fr, e_wr, e_rd});
    chk("class_excl", (al | fr) & (wr | rd), 0);
    chk("adata", adata, e_adata); chk("faddr", faddr, e_faddr);
    chk("waddr", waddr, e_waddr); chk("wdata", wdata, e_wdata);
    chk("raddr", raddr, e_raddr);
    chk("a_done", a_done, exp_done[0]); chk("b_done", b_done, exp_done[1]);
    chk("a_rdata", a_rdata, (exp_done[0] && !err_in) ? exp_rd[0] : 16'h0000);
    chk("b_rdata", b_rdata, (exp_done[1] && !err_in) ? exp_rd[1] : 16'h0000);
    obs_a_gnt = a_gnt; obs_b_gnt = b_gnt; obs_a_done = a_done; obs_b_done = b_done;
    obs_err = err_out; obs_a_rdata = a_rdata; obs_b_rdata = b_rdata; obs_adata = adata;
    for (int c = 0; c < 2; c++) begin
      nxt_rd[c] = 16'h0000;
      if (g[c]) begin
        case (cur[c].op)
          2'd0: if (comb) nxt_rd[c] = cur[1-c].addr;
                else begin nxt_rd[c] = r_cnt; r_cnt = r_cnt + 16'd1; end
          2'd3: nxt_rd[c] = r_mem[cur[c].addr[3:0]];
          2'd2: r_mem[cur[c].addr[3:0]] = cur[c].data;
          default: ;
        endcase
      end
    end
    if (!comb && g[0] && cur_v[1]) r_ptr = 1;
    else if (!comb && g[1] && cur_v[0]) r_ptr = 0;
    if (err_in) r_halt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      exp_done[c] = g[c];
      exp_rd[c] = nxt_rd[c];
      if (g[c]) cur_v[c] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && !cur_v[0] && !cur_v[1]) break;
      cycle();
    end
    chk("drain_timeout", (qa.size() + qb.size()) != 0 || cur_v[0] || cur_v[1], 0);
    cycle();
  endtask

  logic [3:0] gseq;

  initial begin
    err_in = 0; a_req = 0; b_req = 0; a_op = 0; b_op = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    cur_v[0] = 0; cur_v[1] = 0; cur[0] = '0; cur[1] = '0;
    do_reset();

    push(0, 2'd0, 16'h0000, 16'h1234);
    cycle();
    chk("first_adata", obs_adata, 16'h1234);
    cycle();
    chk("first_rdata", obs_a_rdata, 16'h5000);
    chk("first_done", obs_a_done, 1);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(0, 2'd0, 16'h0000, 16'h1111);
      push(1, 2'd0, 16'h0000, 16'h2222);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      gseq[3-i] = obs_a_gnt;
    end
    chk("alt_order", gseq, 4'b1010);
    cycle();
    chk("alt_last_addr", obs_b_rdata, 16'h5003);

    push(0, 2'd2, 16'h5001, 16'hBEEF);
    cycle();
    push(1, 2'd3, 16'h5001, 16'h0000);
    cycle();
    chk("write_done_undef", obs_a_rdata, 16'h0000);
    chk("write_done", obs_a_done, 1);
    cycle();
    chk("read_back", obs_b_rdata, 16'hBEEF);

    push(0, 2'd3, 16'h5001, 0); push(1, 2'd3, 16'h5002, 0);
    push(0, 2'd2, 16'h5003, 16'hAAAA); push(1, 2'd2, 16'h5004, 16'h5555);
    drain();

    for (int i = 0; i < 6; i++) begin
      push(0, 2'd0, 0, 16'h0A0A); push(1, 2'd0, 0, 16'h0B0B);
    end
    cycle();
    err_in = 1;
    cycle();
    chk("err_same_cycle", obs_err, 1);
    err_in = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("halt_no_gnt", {obs_a_gnt, obs_b_gnt}, 0);
    end
    do_reset();
    cycle();
    chk("resume_a_first", {obs_a_gnt, obs_b_gnt}, 2'b10);
    qa.delete(); qb.delete();
    drain();

    do_reset();
    push(0, 2'd0, 0, 16'h7777); push(1, 2'd1, 16'h5002, 0);
    cycle();
`ifdef HEAP_ARB_COMBINE_EN
    chk("comb_gnt", {obs_a_gnt, obs_b_gnt}, 2'b11);
    cycle();
    chk("comb_a_rdata", obs_a_rdata, 16'h5002);
    chk("comb_b_done", obs_b_done, 1);
`else
    chk("nocomb_gnt1", {obs_a_gnt, obs_b_gnt}, 2'b10);
    cycle();
    chk("nocomb_gnt2", {obs_a_gnt, obs_b_gnt}, 2'b01);
`endif
    drain();

    for (int i = 0; i < 400; i++) begin
      if (qa.size() == 0 && !cur_v[0] && $urandom_range(2) != 0)
        push(0, 2'($urandom_range(3)), 16'h5000 | 16'($urandom_range(15)), 16'($urandom));
      if (qb.size() == 0 && !cur_v[1] && $urandom_range(2) != 0)
        push(1, 2'($urandom_range(3)), 16'h5000 | 16'($urandom_range(15)), 16'($urandom));
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/heap_arbiter.md
# heap_arbiter

Two-client arbiter and sequencer in front of the linked-memory allocator (`alloc`). Clients A and B each issue alloc/free/write/read requests over a request/grant handshake. The arbiter drives at most one allocator operation class per cycle and routes each result back to its originator one cycle later. It latches allocator errors and halts all further grants until reset.

## Interface
Parameters:
- `DATA_SZ`, 16, word and address width (matches `alloc`)

Ports (op encoding: 2'b00 alloc, 2'b01 free, 2'b10 write, 2'b11 read):
- `i_clk`  in  1  domain clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_a_req` / `i_b_req`  in  1  client request valid
- `i_a_op` / `i_b_op`  in  2  operation code
- `i_a_addr` / `i_b_addr`  in  DATA_SZ  free/write/read address
- `i_a_data` / `i_b_data`  in  DATA_SZ  alloc initial data / write data
- `o_a_gnt` / `o_b_gnt`  out  1  request accepted this cycle (combinational)
- `o_a_done` / `o_b_done`  out  1  result valid (registered, 1-cycle pulse)
- `o_a_rdata` / `o_b_rdata`  out  DATA_SZ  allocated address (alloc/combined) or read data (read); UNDEF (0x0000) otherwise
- `o_al`, `o_fr`, `o_wr`, `o_rd`  out  1  allocator request strobes
- `o_adata`, `o_faddr`, `o_waddr`, `o_wdata`, `o_raddr`  out  DATA_SZ  allocator operands
- `i_aaddr`, `i_rdata`  in  DATA_SZ  allocator results
- `i_err`  in  1  allocator error strobe
- `o_err`  out  1  sticky error / halted

## Operation
- States: RUN, HALT. Reset enters RUN with priority pointer = A.
- RUN, one requester: grant it and drive exactly one allocator strobe with its operands. All other strobes are 0.
- RUN, both requesting: grant the pointer's client. After any contended grant, the pointer moves to the other client. An uncontended grant leaves the pointer unchanged.
- A client holds `req`/`op`/`addr`/`data` stable until `gnt`. The ungranted client waits; it is never dropped.
- Issue register: captures owner (A/B) and kind (alloc, read, other) for every grant.
- Next cycle: assert `done` to the owner. `rdata` returns `i_aaddr` for alloc, `i_rdata` for read, and UNDEF for free/write.
- Drive operand buses to 0 when no strobe is active. Mem-class and ptr-class strobes are never asserted together.
- `i_err` high in any cycle: set `o_err`, enter HALT, force all grants to 0.
  - The `done` for the offending op still pulses, with `rdata` = UNDEF.
  - HALT is left only by reset.
- Reset mid-operation: pending `done`, issue register and pointer all clear asynchronously. The outstanding op is lost, and the client must reissue it.

## Timing
- Grant decision: same cycle, combinational from `req`, state and pointer. Allocator strobe goes out the same cycle as `gnt`.
- Result latency: `done` exactly 1 cycle after `gnt`. Throughput is 1 op/cycle, and back-to-back grants to one client are allowed.
- `o_err` = sticky flag OR `i_err`, so it is visible in the same cycle as `i_err`. `gnt` is 0 from that cycle onward.
- Reset values: all `gnt`/`done`/strobes 0, all data outputs 0x0000, `o_err` 0.

## Configuration
- `HEAP_ARB_COMBINE_EN` defined:
  - Fires when one client requests alloc, the other requests free, and both are in RUN. Both are granted in the same cycle with `o_al` and `o_fr` both high.
  - Next cycle both get `done`. The alloc client receives `i_aaddr` (the freed address, passed through). The free client receives UNDEF.
  - The pointer does not move.
- Undefined: the pair is arbitrated like any other contention, one per cycle.

## Test plan
- Reset, then A alloc data 0x1234 → `o_al`=1, `o_adata`=0x1234 same cycle; next cycle `o_a_done`=1, `o_a_rdata`=0x5000.
- A and B both alloc every cycle for 4 cycles → grants alternate A,B,A,B. `done` pulses follow one cycle later with addresses 0x5000..0x5003 in grant order.
- A write 0x5001←0xBEEF, then B read 0x5001 → `o_b_done` with `o_b_rdata`=0xBEEF; A gets `done` with UNDEF.
- Two clients both reading or both writing at once → only one strobe and one grant per cycle. Never `o_al|o_fr` together with `o_wr|o_rd`.
- Force `i_err`=1 for one cycle, then keep both requesting → `o_err`=1 from that cycle and no further `gnt`. Deassert `i_rst_n` → `o_err`=0, grants resume with A priority.
- With `HEAP_ARB_COMBINE_EN`: A alloc 0x7777 while B frees 0x5002 → both granted; next cycle `o_a_rdata`=0x5002 and `o_b_done`=1. Without the macro: A is granted first, B the next cycle.
